// File: rtl/instruction_fetch_if.sv
// Instruction memory port between the fetch stage and imem.
// Request/address out, ready/data back.
interface instruction_fetch_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemReady,
    input  ImemData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemReady,
    output ImemData
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches over a ready-qualified imem port.
// A one-entry hold buffer parks a word that arrives while stalled.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            RedirectPC,
  instruction_fetch_if.master    imem,
  output logic [31:0]            PCOut,
  output logic [31:0]            InstructionOut,
  output logic                   Valid
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_ins_q, buf_ins_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] ins_out_q, ins_out_d;
  logic        valid_q, valid_d;

  logic in_fetch;
  logic go;
  logic park;
  logic bubble;
  logic release_buf;

  assign in_fetch    = (state_q == FETCH);
  assign go          = !redirect && in_fetch && imem.ImemReady && !stall;
  assign park        = !redirect && in_fetch && imem.ImemReady && stall;
  assign bubble      = !redirect && in_fetch && !imem.ImemReady && !stall;
  assign release_buf = !redirect && !in_fetch && !stall;

  assign imem.ImemReq  = in_fetch && !reset;
  assign imem.ImemAddr = pc_q;

  assign PCOut          = pc_out_q;
  assign InstructionOut = ins_out_q;
  assign Valid          = valid_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_pc_d  = buf_pc_q;
    buf_ins_d = buf_ins_q;
    pc_out_d  = pc_out_q;
    ins_out_d = ins_out_q;
    valid_d   = valid_q;
    unique case (1'b1)
      redirect: begin
        pc_d      = {RedirectPC[31:2], 2'b00};
        state_d   = FETCH;
        valid_d   = 1'b0;
        ins_out_d = NOP;
      end
      go: begin
        pc_out_d  = pc_q;
        ins_out_d = imem.ImemData;
        valid_d   = 1'b1;
        pc_d      = pc_q + 32'd4;
      end
      park: begin
        buf_pc_d  = pc_q;
        buf_ins_d = imem.ImemData;
        pc_d      = pc_q + 32'd4;
        state_d   = HOLD;
      end
      bubble: begin
        valid_d   = 1'b0;
        ins_out_d = NOP;
      end
      release_buf: begin
        pc_out_d  = buf_pc_q;
        ins_out_d = buf_ins_q;
        valid_d   = 1'b1;
        state_d   = FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      buf_pc_q  <= RESET_PC;
      buf_ins_q <= NOP;
      pc_out_q  <= RESET_PC;
      ins_out_q <= NOP;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_pc_q  <= buf_pc_d;
      buf_ins_q <= buf_ins_d;
      pc_out_q  <= pc_out_d;
      ins_out_q <= ins_out_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: driver pushes expected deliveries,
// a negedge monitor pops and compares each new delivery.
module tb_instruction_fetch;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;
  logic [31:0] pc_out;
  logic [31:0] ins_out;
  logic        valid;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic        last_stall = 1'b1;

  instruction_fetch_if imem ();

  assign imem.ImemReady = ready;
  assign imem.ImemData  = imem.ImemAddr ^ KEY;

  instruction_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .RedirectPC     (redirect_pc),
    .imem           (imem.master),
    .PCOut          (pc_out),
    .InstructionOut (ins_out),
    .Valid          (valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // A delivery is any edge taken with stall low that leaves Valid high.
  always @(posedge clock) last_stall <= stall || reset;

  always @(negedge clock) begin
    if (!reset && !last_stall && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected: got pc %h none expected", pc_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("deliver_pc", pc_out, e);
        chk("deliver_ins", ins_out, e ^ KEY);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    ready = 1'b1;
    step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_ins", ins_out, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_req", {31'b0, imem.ImemReq}, 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("t1_req", {31'b0, imem.ImemReq}, 32'h1);
    chk("t1_addr", imem.ImemAddr, 32'h0);
    #1;
    // 1: zero-wait stream
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    step();
    step();
    // 2: three wait cycles at PC=8
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_addr", imem.ImemAddr, 32'h8);
      chk("t2_valid", {31'b0, valid}, 32'h0);
      chk("t2_nop", ins_out, 32'h0);
    end
    ready = 1'b1;
    exp_q.push_back(32'h8);
    step();
    // 3: stall while memory is ready at PC=C
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_pc_frozen", pc_out, 32'h8);
      chk("t3_req", {31'b0, imem.ImemReq}, 32'h0);
    end
    chk("t3_valid_held", {31'b0, valid}, 32'h1);
    stall = 1'b0;
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    step();
    step();
    // 4: redirect while parked in HOLD
    stall = 1'b1;
    step();
    chk("t4_hold_req", {31'b0, imem.ImemReq}, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    chk("t4_valid", {31'b0, valid}, 32'h0);
    chk("t4_addr", imem.ImemAddr, 32'h100);
    chk("t4_req", {31'b0, imem.ImemReq}, 32'h1);
    chk("t4_pc_held", pc_out, 32'h10);
    redirect = 1'b0;
    stall = 1'b0;
    exp_q.push_back(32'h100);
    step();
    // 5: PC wraps at the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("t5_valid", {31'b0, valid}, 32'h0);
    redirect = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    step();
    step();
    chk("t5_addr", imem.ImemAddr, 32'h4);
    // 6: async reset mid-cycle while waiting on memory
    ready = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_pc", pc_out, 32'h0);
    chk("t6_valid", {31'b0, valid}, 32'h0);
    chk("t6_addr", imem.ImemAddr, 32'h0);
    chk("t6_req", {31'b0, imem.ImemReq}, 32'h0);
    step();
    reset = 1'b0;
    ready = 1'b1;
    exp_q.push_back(32'h0);
    step();
    ready = 1'b0;
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
